// File: rtl/toggle_activity_monitor.sv
// Per-net 0<->1 toggle counter over a programmable window, drained one count per beat.
// Optional running total of all toggles is enabled by defining TOGGLE_MON_TOTAL_EN.
module toggle_activity_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIN_W-1:0]           win_len,
  input  logic [WIDTH-1:0]           probe,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   out_idx,
  output logic [CNT_W-1:0]           out_count,
  output logic                       out_last,
`ifdef TOGGLE_MON_TOTAL_EN
  output logic [CNT_W+$clog2(WIDTH)-1:0] total_count,
`endif
  output logic                       done
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   prev_reg;
  logic [WIN_W-1:0]   remaining_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               done_reg;
  logic [CNT_W-1:0]   cnt_reg [WIDTH];

  logic [WIDTH-1:0]   toggle_vec;
  logic [WIDTH-1:0]   inc_vec;
  logic               accept;
  logic               last_beat;
  logic               xfer;

  assign accept    = (state_reg == IDLE) && start && (win_len != '0);
  assign last_beat = (idx_reg == IDX_W'(WIDTH - 1));
  assign xfer      = (state_reg == DRAIN) && out_ready;

  // Per-net toggle detect; increments stop once a counter is all ones.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_net
      assign toggle_vec[gi] = probe[gi] ^ prev_reg[gi];
      assign inc_vec[gi]    = (state_reg == COUNT) && toggle_vec[gi] && (cnt_reg[gi] != '1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = COUNT;
      COUNT:   if (remaining_reg == WIN_W'(1)) state_next = DRAIN;
      DRAIN:   if (out_ready && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg      <= '0;
      remaining_reg <= '0;
      idx_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= xfer && last_beat;
      if (accept) begin
        prev_reg      <= probe;
        remaining_reg <= win_len;
      end else if (state_reg == COUNT) begin
        prev_reg      <= probe;
        remaining_reg <= remaining_reg - WIN_W'(1);
      end
      // idx returns to 0 after the final beat so it reads 0 while idle
      if (state_reg == COUNT && remaining_reg == WIN_W'(1)) begin
        idx_reg <= '0;
      end else if (xfer) begin
        idx_reg <= last_beat ? '0 : idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst || accept) begin
        cnt_reg[i] <= '0;
      end else if (inc_vec[i]) begin
        cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DRAIN);
  assign out_idx   = idx_reg;
  assign out_count = out_valid ? cnt_reg[idx_reg] : '0;
  assign out_last  = out_valid && last_beat;
  assign done      = done_reg;

`ifdef TOGGLE_MON_TOTAL_EN
  localparam int TOT_W = CNT_W + IDX_W;

  logic [TOT_W-1:0] total_reg;
  logic [IDX_W:0]   pop;
  logic [TOT_W:0]   total_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + (IDX_W + 1)'(toggle_vec[i]);
    end
    total_sum = {1'b0, total_reg} + (TOT_W + 1)'(pop);
  end

  // Carry out of the sum means the total has hit its ceiling.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      total_reg <= '0;
    end else if (state_reg == COUNT) begin
      total_reg <= total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
    end
  end

  assign total_count = total_reg;
`endif

endmodule
